pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use / branch-operand stalls, taken-branch flush, memory freeze and timeout.
// Optional macro HAZARD_STALL_COUNT_EN adds the 16-bit stallCycles counter output.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rsID,
    input  logic [4:0] rtID,
    input  logic       useRtID,
    input  logic       branchID,
    input  logic       branchTakenID,
    input  logic [4:0] destEX,
    input  logic       regWriteEX,
    input  logic       memReadEX,
    input  logic [4:0] destMEM,
    input  logic       memReadMEM,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       ifidWrite,
    output logic       idexBubble,
    output logic       ifidFlush,
    output logic       pipeWrite,
    output logic [1:0] state,
    output logic       memTimeout
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [15:0] stallCycles
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    logic       ex_match;
    logic       mem_match;
    logic       hazard;
    logic       taken;
    logic       started;
    logic       pending_flush;
    logic       next_pending;
    logic [1:0] next_state;
    logic [7:0] wait_cnt;

    assign ex_match  = (destEX != 5'd0) &&
                       ((destEX == rsID) || (useRtID && (destEX == rtID)));
    assign mem_match = (destMEM != 5'd0) &&
                       ((destMEM == rsID) || (useRtID && (destMEM == rtID)));

    assign hazard = (memReadEX && ex_match) ||
                    (branchID && regWriteEX && ex_match) ||
                    (branchID && memReadMEM && mem_match);

    assign taken = branchID && branchTakenID && !hazard;

    // Outputs stay quiet until the first clock edge after reset release (started).
    always_comb begin
        pcWrite      = 1'b0;
        ifidWrite    = 1'b0;
        idexBubble   = 1'b0;
        ifidFlush    = 1'b0;
        pipeWrite    = 1'b0;
        next_state   = state;
        next_pending = pending_flush;

        if (!rst_n || !started) begin
            next_state   = ST_RUN;
            next_pending = 1'b0;
        end else if (!memReady) begin
            next_state = ST_FREEZE;
            if (taken) begin
                next_pending = 1'b1;
            end
        end else begin
            next_pending = 1'b0;
            pipeWrite    = 1'b1;
            if (hazard) begin
                idexBubble = 1'b1;
            end else begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
            end
            // A flush cycle never flushes again; a taken branch there just extends FLUSH.
            if (pending_flush || (taken && (state != ST_FLUSH))) begin
                ifidFlush = 1'b1;
            end
            if (ifidFlush || taken) begin
                next_state = ST_FLUSH;
            end else begin
                next_state = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started       <= 1'b0;
            state         <= ST_RUN;
            pending_flush <= 1'b0;
            wait_cnt      <= 8'd0;
            memTimeout    <= 1'b0;
        end else begin
            started       <= 1'b1;
            state         <= next_state;
            pending_flush <= next_pending;
            if (started) begin
                if (memReady) begin
                    wait_cnt <= 8'd0;
                end else if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (wait_cnt == WAIT_LIMIT) begin
                    memTimeout <= 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles <= 16'd0;
        end else if (started && !pcWrite && (stallCycles != 16'hFFFF)) begin
            stallCycles <= stallCycles + 16'd1;
        end
    end
`endif

endmodule
